// File: rtl/code_lock_fsm.sv
// code_lock_fsm: N-digit keypad lock with full-sequence evaluation, fail
// counting with timed lockout, auto-relock from OPEN and in-field code
// reprogramming through a PROG state.
module code_lock_fsm #(
   parameter int N_DIGITS       = 4,
   parameter int DIGIT_W        = 4,
   parameter logic [N_DIGITS*DIGIT_W-1:0] RESET_CODE = 16'h1234,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 16,
   parameter int UNLOCK_CYCLES  = 32
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              enter,
   input  logic [DIGIT_W-1:0]                digit,
   input  logic                              prog_req,
   output logic [1:0]                        state,
   output logic                              locked_led,
   output logic                              unlocked_led,
   output logic                              lockout_led,
   output logic                              error_led,
   output logic [$clog2(N_DIGITS+1)-1:0]     progress,
   output logic [$clog2(MAX_FAILS+1)-1:0]    fail_count
);

   localparam int CW   = N_DIGITS * DIGIT_W;
   localparam int PW   = $clog2(N_DIGITS + 1);
   localparam int FW   = $clog2(MAX_FAILS + 1);
   localparam int TMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [1:0] ST_LOCKED  = 2'd0;
   localparam logic [1:0] ST_OPEN    = 2'd1;
   localparam logic [1:0] ST_PROG    = 2'd2;
   localparam logic [1:0] ST_LOCKOUT = 2'd3;

   localparam logic [PW-1:0] LAST_IDX      = PW'(N_DIGITS - 1);
   localparam logic [FW-1:0] FAIL_LIMIT    = FW'(MAX_FAILS);
   // Timer counts down to zero; the zero cycle is the last cycle of the dwell.
   localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
   localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] progress_q, progress_d;
   logic          mismatch_q, mismatch_d;
   logic [FW-1:0] fail_count_q, fail_count_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          error_q, error_d;
   logic [CW-1:0] code_q, code_d;
   logic [CW-1:0] shadow_q, shadow_d;

   logic [DIGIT_W-1:0] code_digit;
   logic [CW-1:0]      shadow_wr;
   logic               seq_bad;
   logic [FW-1:0]      fail_inc;
   logic               timer_zero;

   // Select the expected code digit and build the shadow with the new digit merged in.
   always_comb begin
      code_digit = '0;
      shadow_wr  = shadow_q;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (progress_q == PW'(i)) begin
            code_digit = code_q[CW-1-i*DIGIT_W -: DIGIT_W];
            shadow_wr[CW-1-i*DIGIT_W -: DIGIT_W] = digit;
         end
      end
   end

   assign seq_bad    = mismatch_q | (digit != code_digit);
   assign fail_inc   = (fail_count_q == FAIL_LIMIT) ? fail_count_q : fail_count_q + 1'b1;
   assign timer_zero = (timer_q == '0);

   // Next-state and datapath update for every state.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d      = state_q;
      progress_d   = progress_q;
      mismatch_d   = mismatch_q;
      fail_count_d = fail_count_q;
      timer_d      = timer_q;
      error_d      = 1'b0;
      code_d       = code_q;
      shadow_d     = shadow_q;

      case (state_q)
         ST_LOCKED: begin
            if (enter) begin
               if (progress_q == LAST_IDX) begin
                  // Whole sequence seen: judge it only now, never early.
                  progress_d = '0;
                  mismatch_d = 1'b0;
                  if (!seq_bad) begin
                     state_d      = ST_OPEN;
                     fail_count_d = '0;
                     timer_d      = UNLOCK_LOAD;
                  end else begin
                     error_d      = 1'b1;
                     fail_count_d = fail_inc;
                     if (fail_inc == FAIL_LIMIT) begin
                        state_d = ST_LOCKOUT;
                        timer_d = LOCKOUT_LOAD;
                     end
                  end
               end else begin
                  mismatch_d = seq_bad;
                  progress_d = progress_q + 1'b1;
               end
            end
         end

         ST_OPEN: begin
            // An enter on the expiry cycle takes precedence over auto-relock.
            if (enter) begin
               if (prog_req) begin
                  state_d    = ST_PROG;
                  progress_d = '0;
                  timer_d    = UNLOCK_LOAD;
               end else begin
                  state_d = ST_LOCKED;
               end
            end else if (timer_zero) begin
               state_d = ST_LOCKED;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         ST_PROG: begin
            if (enter) begin
               shadow_d = shadow_wr;
               if (progress_q == LAST_IDX) begin
                  // Swap the full new code in at once; no partial code is ever live.
                  code_d     = shadow_wr;
                  state_d    = ST_LOCKED;
                  progress_d = '0;
               end else begin
                  progress_d = progress_q + 1'b1;
                  timer_d    = UNLOCK_LOAD;
               end
            end else if (timer_zero) begin
               state_d    = ST_LOCKED;
               progress_d = '0;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         default: begin
            // LOCKOUT: keypad ignored until the timer runs out.
            if (timer_zero) begin
               state_d      = ST_LOCKED;
               fail_count_d = '0;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
      endcase
   end

   // State registers with synchronous reset restoring the power-on code.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         state_q      <= ST_LOCKED;
         progress_q   <= '0;
         mismatch_q   <= 1'b0;
         fail_count_q <= '0;
         timer_q      <= '0;
         error_q      <= 1'b0;
         // NOTE: the code and shadow registers are reset too, so reset always restores a known code.
         code_q       <= RESET_CODE;
         shadow_q     <= '0;
      end else begin
         state_q      <= state_d;
         progress_q   <= progress_d;
         mismatch_q   <= mismatch_d;
         fail_count_q <= fail_count_d;
         timer_q      <= timer_d;
         error_q      <= error_d;
         code_q       <= code_d;
         shadow_q     <= shadow_d;
      end
   end

   assign state        = state_q;
   assign locked_led   = (state_q != ST_OPEN);
   assign unlocked_led = (state_q == ST_OPEN);
   assign lockout_led  = (state_q == ST_LOCKOUT);
   assign error_led    = error_q;
   assign progress     = progress_q;
   assign fail_count   = fail_count_q;

endmodule

// File: doc/code_lock_fsm.md
Name: code_lock_fsm

Overview:
- Parametrised successor of the single-digit lock FSM: a Moore-style keypad lock checking an N-digit sequence against an on-chip code register.
- Adds full-sequence evaluation (no early reject), fail counting with timed lockout, auto-relock, and in-field reprogramming of the code.
- Sits between the debounced keypad front end (enter strobe + digit) and the board LEDs.

Parameters:
- N_DIGITS, 4, digits per code (>=2)
- DIGIT_W, 4, bits per digit
- RESET_CODE, 16'h1234, code after reset, N_DIGITS*DIGIT_W bits; first-entered digit is the most-significant field
- MAX_FAILS, 3, consecutive failed sequences that trigger lockout (>=1)
- LOCKOUT_CYCLES, 16, lockout duration in clk cycles (>=1)
- UNLOCK_CYCLES, 32, idle cycles before auto-relock from OPEN and before abort from PROG (>=1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- enter  in  1  one-cycle entry strobe; level-sampled, so every high cycle is one entry
- digit  in  DIGIT_W  digit value, sampled when enter=1
- prog_req  in  1  sampled with enter in OPEN: 1 = enter PROG, 0 = relock
- state  out  2  LOCKED=0, OPEN=1, PROG=2, LOCKOUT=3
- locked_led  out  1  state!=OPEN
- unlocked_led  out  1  state==OPEN
- lockout_led  out  1  state==LOCKOUT
- error_led  out  1  registered one-cycle pulse on failed sequence
- progress  out  $clog2(N_DIGITS+1)  digits accepted in current sequence; 0 in OPEN/LOCKOUT
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failed sequences

Behaviour:
- Reset (sync, highest priority): state=LOCKED, progress=0, mismatch flag=0, fail_count=0, timer=0, error_led=0, code=RESET_CODE, shadow code cleared. Reset mid-sequence or mid-PROG discards all partial input.
- All state, counters and error_led are registered; LED outputs decode state combinationally.
- LOCKED, enter: compare digit to code field[progress]; OR mismatch into a sticky flag; progress++. No transition before the N_DIGITS-th entry.
  - Final entry, all digits matched: next cycle state=OPEN, fail_count=0, progress=0, timer starts.
  - Final entry, any mismatch: progress=0, flag=0, error_led=1 for exactly one cycle, fail_count++.
  - If the increment reaches MAX_FAILS, state=LOCKOUT and the timer starts; otherwise stay LOCKED.
- OPEN: lasts exactly UNLOCK_CYCLES cycles with no enter, then state=LOCKED.
  - enter with prog_req=0: state=LOCKED next cycle.
  - enter with prog_req=1: state=PROG, progress=0.
  - enter on the expiry cycle wins over auto-relock.
- PROG: each enter writes digit into shadow field[progress], progress++, and restarts the UNLOCK_CYCLES idle timer.
  - After the N_DIGITS-th entry, code is replaced by shadow atomically, state=LOCKED, progress=0.
  - Idle expiry: abort with code unchanged, state=LOCKED, progress=0.
  - enter on the expiry cycle is accepted.
- LOCKOUT: lasts exactly LOCKOUT_CYCLES cycles, then state=LOCKED with fail_count=0. enter is ignored for the whole interval, including the expiry cycle; progress stays 0.
- Timer width is $clog2(max(LOCKOUT_CYCLES,UNLOCK_CYCLES)+1). It is loaded on state entry, or on PROG accept, so the dwell equals the parameter exactly.
- fail_count saturates at MAX_FAILS and never wraps.
- Latency: every enter takes effect on the next clk edge; outputs update in the following cycle.

Test Plan:
- Reset, then enter 1,2,3,4 on consecutive cycles -> progress 1,2,3 then state=OPEN, unlocked_led=1, fail_count=0, error_led never high.
- Enter 1,9,3,4 -> state stays LOCKED through all four entries; error_led high exactly one cycle after the 4th; fail_count=1; progress=0.
- Three bad sequences -> state=LOCKOUT for exactly 16 cycles with enter ignored throughout; then LOCKED, fail_count=0; then 1,2,3,4 opens.
- Unlock, then no enter -> state returns to LOCKED exactly 32 cycles after entering OPEN. Repeat with enter+prog_req=0 on cycle 32 -> same LOCKED result via the enter path; with prog_req=1 on that cycle -> PROG.
- Unlock, enter+prog_req=1, then digits 5,6,7,8 -> LOCKED; 1,2,3,4 now fails; 5,6,7,8 opens. PROG with 5,6 then 32 idle cycles -> LOCKED, code still 1234.
- Enter 1,2 then assert reset -> progress=0, state=LOCKED. After programming 5678, reset -> code back to 1234.
